// File: rtl/aes_pkg.sv
// Shared encodings for the AES round sequencer: key sizes, round limits
// and the controller state enum.
package aes_pkg;

  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;

  localparam int NR_BASE   = 10;
  localparam int MAX_ROUND = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/step_prescaler.sv
// Down-counter that emits a one-cycle terminal-count tick every STEP_DIV
// enabled cycles; load forces the counter back to STEP_DIV-1.
module step_prescaler #(
  parameter int STEP_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (en) begin
      count <= (count == '0) ? RELOAD : count - CW'(1);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Round controller for the AES demo top: latches the key size, then walks
// a shared round index through cipher (0..Nr) and decipher (Nr+1..2*Nr).
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int STEP_DIV = 50000000,
  parameter int RW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    key_sel,
  input  logic          auto,
  input  logic          step,
  input  logic          match,
  output logic [RW-1:0] round,
  output logic [3:0]    nr,
  output logic [1:0]    sel_q,
  output logic          phase,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err,
  output logic [1:0]    fsm_state
);

  // start and step are single-cycle pulses with no ready/backpressure:
  // start is accepted only in IDLE/DONE, step only in RUN with auto_q=0.
  state_t        state_q, state_d;
  logic [RW-1:0] round_d, last_round;
  logic [1:0]    sel_d;
  logic          auto_q, auto_d;
  logic          pass_d, err_d, done_d;
  logic          load, tick, adv;

  assign nr         = 4'd10 + {1'b0, sel_q, 1'b0};
  assign last_round = RW'({nr, 1'b0});
  assign phase      = (round > RW'(nr));
  assign busy       = (state_q == ST_RUN);
  assign fsm_state  = state_q;
  assign adv        = auto_q ? tick : step;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (busy & auto_q),
    .load (load),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    round_d = round;
    sel_d   = sel_q;
    auto_d  = auto_q;
    pass_d  = pass;
    err_d   = err;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pass_d = 1'b0;
          if (key_sel == 2'd3) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_RUN;
            round_d = '0;
            sel_d   = key_sel;
            auto_d  = auto;
            load    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (round < last_round) begin
            round_d = round + RW'(1);
          end else begin
            // round stays at 2*Nr so the display keeps the last decipher byte
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = match;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round   <= '0;
      sel_q   <= KS_128;
      auto_q  <= 1'b0;
      pass    <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      round   <= round_d;
      sel_q   <= sel_d;
      auto_q  <= auto_d;
      pass    <= pass_d;
      err     <= err_d;
      done    <= done_d;
    end
  end

endmodule
